// File: rtl/adc_regs_pkg.sv
// Package: adc_regs_pkg
// Purpose : Shared constants and types for the ADC channel register file.
//           It holds the byte register map offsets, the bit positions inside the
//           config register, the sequencer channel-id width and the type of the
//           host write byte counter.
// Ports   : none (package only)
package adc_regs_pkg;

  // Width of a modular-ADC sequencer channel id
  localparam int CH_ID_W = 5;

  // Byte register map
  localparam logic [7:0] REG_CONFIG  = 8'h00;  // RW config
  localparam logic [7:0] REG_FRAMES  = 8'h01;  // RO frame counter
  localparam logic [7:0] REG_CH_BASE = 8'h02;  // slot k: low at BASE+2k, high at BASE+2k+1

  // Config register bit positions
  localparam int CFG_RUN_BIT    = 0;
  localparam int CFG_AVG_EN_BIT = 1;

  // Progress through a host write: the first byte is the pointer, later bytes are data
  typedef enum logic [1:0] {
    BYTES_NONE = 2'd0,
    BYTES_PTR  = 2'd1,
    BYTES_DATA = 2'd2
  } byte_cnt_e;

endpackage

// File: rtl/rise_edge_det.sv
// Module : rise_edge_det
// Purpose: Detects a rising edge of a level strobe.
//          It keeps two flops of history and registers the pulse, so an
//          action that uses the pulse fires two clk_core edges after the first
//          edge at which the level was sampled high.
// Ports  : clk_core - clock
//          reset    - synchronous, active-high
//          level    - strobe level from the I2C slave
//          pulse    - one-cycle registered pulse per rising edge
module rise_edge_det (
  input  logic clk_core,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic [1:0] hist_q, hist_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    hist_d  = {hist_q[0], level};
    pulse_d = hist_q[0] & ~hist_q[1];
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      hist_q  <= 2'b00;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/adc_channel_regfile.sv
// Module : adc_channel_regfile
// Purpose: ADC register file between the modular-ADC sequencer response stream
//          and the I2C slave byte interface. It captures NUM_CH mapped channels,
//          optionally IIR-averages them, and publishes a coherent snapshot on
//          each endofpacket. The I2C host sees an auto-incrementing byte
//          register map. A write to config issues a one-cycle sequencer CSR
//          write pulse.
// Ports  : clk_core, reset (sync, active-high)
//          adc_response_{valid,channel,data,endofpacket} - sequencer samples
//          slave_{asserted,in_tx_mode,tx_request,rx_available,rx_buffer} - I2C slave
//          slave_tx_buffer - byte returned to the host
//          adc_sequencer_csr_write/_writedata - run-bit write to the sequencer
//          adc_config - config register
module adc_channel_regfile
  import adc_regs_pkg::*;
#(
  parameter int                          NUM_CH    = 5,
  parameter int                          DATA_W    = 12,
  parameter logic [NUM_CH*CH_ID_W-1:0]   CH_MAP    = {5'd6, 5'd4, 5'd3, 5'd2, 5'd1},
  parameter int                          AVG_SHIFT = 3
) (
  input  logic                clk_core,
  input  logic                reset,
  input  logic                adc_response_valid,
  input  logic [CH_ID_W-1:0]  adc_response_channel,
  input  logic [DATA_W-1:0]   adc_response_data,
  input  logic                adc_response_endofpacket,
  input  logic                slave_asserted,
  input  logic                slave_in_tx_mode,
  input  logic                slave_tx_request,
  input  logic                slave_rx_available,
  input  logic [7:0]          slave_rx_buffer,
  output logic [7:0]          slave_tx_buffer,
  output logic                adc_sequencer_csr_write,
  output logic [31:0]         adc_sequencer_csr_writedata,
  output logic [7:0]          adc_config
);

  // ---------------------------------------------------------------------------
  // Host strobe edge detection
  // ---------------------------------------------------------------------------
  logic tx_pulse, rx_pulse;

  rise_edge_det u_tx_edge (
    .clk_core (clk_core),
    .reset    (reset),
    .level    (slave_tx_request),
    .pulse    (tx_pulse)
  );

  rise_edge_det u_rx_edge (
    .clk_core (clk_core),
    .reset    (reset),
    .level    (slave_rx_available),
    .pulse    (rx_pulse)
  );

  logic rd_fire, wr_fire;
  assign rd_fire = tx_pulse & slave_asserted &  slave_in_tx_mode;
  assign wr_fire = rx_pulse & slave_asserted & ~slave_in_tx_mode;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [7:0]  pointer_q, pointer_d;
  byte_cnt_e   byte_cnt_q, byte_cnt_d;
  logic [7:0]  config_q, config_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        csr_write_q, csr_write_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;

  logic avg_en;
  assign avg_en = config_q[CFG_AVG_EN_BIT];

  // ---------------------------------------------------------------------------
  // Per-slot capture, snapshot and read shadow
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]       match, hit;
  logic [NUM_CH-1:0]       lo_sel, hi_sel;
  logic [NUM_CH-1:0][7:0]  lo_byte, hi_byte;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    localparam logic [7:0] LO_ADDR = 8'(int'(REG_CH_BASE) + 2 * gi);
    localparam logic [7:0] HI_ADDR = 8'(int'(REG_CH_BASE) + 2 * gi + 1);

    logic [DATA_W-1:0]        live_q, live_d;
    logic [DATA_W-1:0]        snap_q, snap_d;
    logic [7:0]               shadow_q, shadow_d;
    logic                     shadow_vld_q, shadow_vld_d;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   step;
    logic [15:0]              snap16;

    assign match[gi] = adc_response_valid &&
                       (adc_response_channel == CH_MAP[gi*CH_ID_W +: CH_ID_W]);

    // Duplicate ids in CH_MAP: only the lowest matching slot captures
    if (gi == 0) begin : g_first
      assign hit[gi] = match[gi];
    end else begin : g_rest
      assign hit[gi] = match[gi] & ~(|match[gi-1:0]);
    end

    assign lo_sel[gi] = (pointer_q == LO_ADDR);
    assign hi_sel[gi] = (pointer_q == HI_ADDR);
    assign snap16     = 16'(snap_q);
    assign lo_byte[gi] = snap16[7:0];
    // A high-byte read that follows a low-byte read returns the high byte
    // captured together with that low byte.
    assign hi_byte[gi] = shadow_vld_q ? shadow_q : snap16[15:8];

    always_comb begin
      // The sign bit of the difference is real, so the shift must be arithmetic.
      diff = $signed({1'b0, adc_response_data}) - $signed({1'b0, live_q});
      step = diff >>> AVG_SHIFT;

      live_d = live_q;
      if (hit[gi]) begin
        live_d = avg_en ? (live_q + step[DATA_W-1:0]) : adc_response_data;
      end

      // The snapshot takes live_d, so a sample arriving with endofpacket is included
      snap_d = snap_q;
      if (adc_response_endofpacket) begin
        snap_d = live_d;
      end

      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      if (rd_fire && lo_sel[gi]) begin
        shadow_d     = snap16[15:8];
        shadow_vld_d = 1'b1;
      end else if (rd_fire && hi_sel[gi]) begin
        shadow_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk_core) begin
      if (reset) begin
        live_q       <= '0;
        snap_q       <= '0;
        shadow_q     <= 8'h00;
        shadow_vld_q <= 1'b0;
      end else begin
        live_q       <= live_d;
        snap_q       <= snap_d;
        shadow_q     <= shadow_d;
        shadow_vld_q <= shadow_vld_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: unmapped addresses read as zero
  // ---------------------------------------------------------------------------
  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    if (pointer_q == REG_CONFIG) begin
      rd_byte = config_q;
    end else if (pointer_q == REG_FRAMES) begin
      rd_byte = frame_q;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (lo_sel[k]) rd_byte = lo_byte[k];
      if (hi_sel[k]) rd_byte = hi_byte[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Host protocol and frame counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pointer_d   = pointer_q;
    byte_cnt_d  = byte_cnt_q;
    config_d    = config_q;
    frame_d     = frame_q;
    tx_buf_d    = tx_buf_q;
    csr_write_d = 1'b0;
    csr_wdata_d = csr_wdata_q;

    if (adc_response_endofpacket) begin
      frame_d = frame_q + 8'd1;
    end

    if (!slave_asserted) begin
      // The pointer is kept across transactions; only the byte count restarts
      byte_cnt_d = BYTES_NONE;
    end else if (wr_fire) begin
      if (byte_cnt_q == BYTES_NONE) begin
        pointer_d  = slave_rx_buffer;
        byte_cnt_d = BYTES_PTR;
      end else begin
        if (pointer_q == REG_CONFIG) begin
          config_d    = slave_rx_buffer;
          csr_wdata_d = {31'b0, slave_rx_buffer[CFG_RUN_BIT]};
          csr_write_d = 1'b1;
        end
        pointer_d  = pointer_q + 8'd1;
        byte_cnt_d = BYTES_DATA;
      end
    end else if (rd_fire) begin
      tx_buf_d  = rd_byte;
      pointer_d = pointer_q + 8'd1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      pointer_q   <= 8'h00;
      byte_cnt_q  <= BYTES_NONE;
      config_q    <= 8'h00;
      frame_q     <= 8'h00;
      tx_buf_q    <= 8'h00;
      csr_write_q <= 1'b0;
      csr_wdata_q <= 32'h0;
    end else begin
      pointer_q   <= pointer_d;
      byte_cnt_q  <= byte_cnt_d;
      config_q    <= config_d;
      frame_q     <= frame_d;
      tx_buf_q    <= tx_buf_d;
      csr_write_q <= csr_write_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  assign slave_tx_buffer             = tx_buf_q;
  assign adc_sequencer_csr_write     = csr_write_q;
  assign adc_sequencer_csr_writedata = csr_wdata_q;
  assign adc_config                  = config_q;

endmodule

// File: tb/tb_adc_channel_regfile.sv
// Testbench for adc_channel_regfile: directed steps with hand-computed
// expectations and a small IIR model for the averaging sequence.
module tb_adc_channel_regfile;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        adc_response_valid;
  logic [4:0]  adc_response_channel;
  logic [11:0] adc_response_data;
  logic        adc_response_endofpacket;
  logic        slave_asserted;
  logic        slave_in_tx_mode;
  logic        slave_tx_request;
  logic        slave_rx_available;
  logic [7:0]  slave_rx_buffer;
  logic [7:0]  slave_tx_buffer;
  logic        adc_sequencer_csr_write;
  logic [31:0] adc_sequencer_csr_writedata;
  logic [7:0]  adc_config;

  int n_checks = 0;
  int n_fail   = 0;

  adc_channel_regfile dut (
    .clk_core                    (clk_core),
    .reset                       (reset),
    .adc_response_valid          (adc_response_valid),
    .adc_response_channel        (adc_response_channel),
    .adc_response_data           (adc_response_data),
    .adc_response_endofpacket    (adc_response_endofpacket),
    .slave_asserted              (slave_asserted),
    .slave_in_tx_mode            (slave_in_tx_mode),
    .slave_tx_request            (slave_tx_request),
    .slave_rx_available          (slave_rx_available),
    .slave_rx_buffer             (slave_rx_buffer),
    .slave_tx_buffer             (slave_tx_buffer),
    .adc_sequencer_csr_write     (adc_sequencer_csr_write),
    .adc_sequencer_csr_writedata (adc_sequencer_csr_writedata),
    .adc_config                  (adc_config)
  );

  always #5 clk_core = ~clk_core;

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [4:0] ch, input logic [11:0] data, input logic eop);
    adc_response_valid       = 1'b1;
    adc_response_channel     = ch;
    adc_response_data        = data;
    adc_response_endofpacket = eop;
    step();
    adc_response_valid       = 1'b0;
    adc_response_endofpacket = 1'b0;
  endtask

  // rx level rise, then wait until the action edge has passed, plus a gap
  task automatic wr_byte(input logic [7:0] b);
    slave_rx_buffer    = b;
    slave_rx_available = 1'b1;
    step();
    slave_rx_available = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic rd_byte(output logic [7:0] b);
    slave_tx_request = 1'b1;
    step();
    slave_tx_request = 1'b0;
    step();
    step();
    b = slave_tx_buffer;
    step();
  endtask

  // Start a transaction and load the pointer, then turn around to host-read
  task automatic set_ptr(input logic [7:0] p);
    slave_asserted   = 1'b1;
    slave_in_tx_mode = 1'b0;
    wr_byte(p);
    slave_in_tx_mode = 1'b1;
  endtask

  task automatic end_xfer();
    slave_asserted   = 1'b0;
    slave_in_tx_mode = 1'b0;
    step();
    step();
  endtask

  task automatic wr_config(input logic [7:0] v);
    slave_asserted   = 1'b1;
    slave_in_tx_mode = 1'b0;
    wr_byte(8'h00);
    wr_byte(v);
    end_xfer();
  endtask

  initial begin
    logic [7:0] b;
    int         model;
    bit         saw_pulse;

    reset = 1'b1;
    adc_response_valid = 1'b0;
    adc_response_channel = 5'd0;
    adc_response_data = 12'h000;
    adc_response_endofpacket = 1'b0;
    slave_asserted = 1'b0;
    slave_in_tx_mode = 1'b0;
    slave_tx_request = 1'b0;
    slave_rx_available = 1'b0;
    slave_rx_buffer = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_tx_buf", 32'(slave_tx_buffer), 32'h00);
    check("rst_csr_wr", 32'(adc_sequencer_csr_write), 32'h0);
    check("rst_csr_wd", adc_sequencer_csr_writedata, 32'h0);
    check("rst_config", 32'(adc_config), 32'h00);

    // 1: capture and snapshot, then read back
    send(5'd1, 12'h123, 1'b0);
    send(5'd6, 12'hABC, 1'b1);
    set_ptr(8'h02);
    rd_byte(b); check("t1_slot0_lo", 32'(b), 32'h23);
    rd_byte(b); check("t1_slot0_hi", 32'(b), 32'h01);
    rd_byte(b); check("t1_slot1_lo", 32'(b), 32'h00);
    end_xfer();
    set_ptr(8'h0A);
    rd_byte(b); check("t1_slot4_lo", 32'(b), 32'hBC);
    rd_byte(b); check("t1_slot4_hi", 32'(b), 32'h0A);
    end_xfer();
    set_ptr(8'h01);
    rd_byte(b); check("t1_frames", 32'(b), 32'h01);
    end_xfer();

    // 2: config write with one-cycle csr pulse
    slave_asserted   = 1'b1;
    slave_in_tx_mode = 1'b0;
    wr_byte(8'h00);
    slave_rx_buffer    = 8'h01;
    slave_rx_available = 1'b1;
    step();
    slave_rx_available = 1'b0;
    step();
    check("t2_csr_early", 32'(adc_sequencer_csr_write), 32'h0);
    step();
    check("t2_csr_pulse", 32'(adc_sequencer_csr_write), 32'h1);
    check("t2_csr_wdata", adc_sequencer_csr_writedata, 32'h1);
    check("t2_config", 32'(adc_config), 32'h01);
    step();
    check("t2_csr_end", 32'(adc_sequencer_csr_write), 32'h0);
    slave_in_tx_mode = 1'b1;
    rd_byte(b); check("t2_ptr_frames", 32'(b), 32'h01);
    end_xfer();

    // 3: averaging, step toward 0x800 ten times, then one step down to 0
    wr_config(8'h02);
    check("t3_csr_wd_run0", adc_sequencer_csr_writedata, 32'h0);
    model = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) begin
        send(5'd2, 12'h800, 1'b1);
        model = model + ((32'sh800 - model) >>> 3);
      end else begin
        send(5'd2, 12'h000, 1'b1);
        model = model + ((0 - model) >>> 3);
      end
      set_ptr(8'h04);
      rd_byte(b); check($sformatf("t3_avg%0d_lo", i), 32'(b), 32'(model & 8'hFF));
      rd_byte(b); check($sformatf("t3_avg%0d_hi", i), 32'(b), 32'((model >> 8) & 8'hFF));
      end_xfer();
    end
    wr_config(8'h00);

    // 4: low/high coherence across a snapshot update
    set_ptr(8'h02);
    rd_byte(b); check("t4_old_lo", 32'(b), 32'h23);
    send(5'd1, 12'h456, 1'b1);
    rd_byte(b); check("t4_shadow_hi", 32'(b), 32'h01);
    end_xfer();
    set_ptr(8'h02);
    rd_byte(b); check("t4_new_lo", 32'(b), 32'h56);
    rd_byte(b); check("t4_new_hi", 32'(b), 32'h04);
    end_xfer();

    // 5: sample and endofpacket together; frame counter wrap (now 14)
    send(5'd6, 12'h5A5, 1'b1);
    set_ptr(8'h0A);
    rd_byte(b); check("t5_bypass_lo", 32'(b), 32'hA5);
    rd_byte(b); check("t5_bypass_hi", 32'(b), 32'h05);
    end_xfer();
    for (int i = 0; i < 241; i++) send(5'd0, 12'hFFF, 1'b1);
    set_ptr(8'h01);
    rd_byte(b); check("t5_frames_ff", 32'(b), 32'hFF);
    end_xfer();
    send(5'd0, 12'hFFF, 1'b1);
    set_ptr(8'h01);
    rd_byte(b); check("t5_frames_wrap", 32'(b), 32'h00);
    end_xfer();
    set_ptr(8'h02);
    rd_byte(b); check("t5_unmapped_lo", 32'(b), 32'h56);
    end_xfer();

    // 6: pointer wrap, then reset in the middle of a config write
    wr_config(8'h81);
    check("t6_config", 32'(adc_config), 32'h81);
    set_ptr(8'hFF);
    rd_byte(b); check("t6_rd_ff", 32'(b), 32'h00);
    rd_byte(b); check("t6_rd_cfg", 32'(b), 32'h81);
    rd_byte(b); check("t6_rd_frames", 32'(b), 32'h00);
    end_xfer();

    slave_asserted   = 1'b1;
    slave_in_tx_mode = 1'b0;
    wr_byte(8'h00);
    slave_rx_buffer    = 8'h55;
    slave_rx_available = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    slave_rx_available = 1'b0;
    saw_pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (adc_sequencer_csr_write) saw_pulse = 1'b1;
      step();
    end
    check("t6_rst_no_csr", 32'(saw_pulse), 32'h0);
    check("t6_rst_config", 32'(adc_config), 32'h00);
    check("t6_rst_csr_wd", adc_sequencer_csr_writedata, 32'h0);
    end_xfer();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
